// File: rtl/alu_pkg.sv
// Shared opcode encodings, issuer FSM state type and opcode legality check.
// No logic of its own: no latency and no flow control here.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO; rd_dat is a register loaded from the head entry on pop (1-cycle read).
// Backpressure: push ignored while full, pop ignored while empty; no full-bypass.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_dat <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_dat <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, issues them to a combinational ALU and returns tagged results; accept->rsp_valid in 2 cycles.
// Backpressure: cmd_ready drops while the FIFO is full; a stalled rsp holds RESP and leaves rsp_* stable.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_in1,
  input  logic [WIDTH-1:0]     cmd_in2,
  input  logic [3:0]           cmd_op,
  input  logic [TAG_W-1:0]     cmd_tag,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  output logic [3:0]           alu_op,
  output logic                 alu_invalid_data,
  input  logic [2*WIDTH-1:0]   alu_out,
  input  logic                 alu_zero,
  input  logic                 alu_error,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_error,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_errs
);

  localparam int ENT_W = TAG_W + 4 + 2 * WIDTH;

  state_t             state;
  state_t             state_nxt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               capture;
  logic               rsp_hs;
  logic               rdy_en;
  logic [ENT_W-1:0]   head;
  logic [TAG_W-1:0]   issue_tag;

  // Holds cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  assign cmd_ready = rdy_en && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;

  alu_cmd_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_dat ({cmd_tag, cmd_op, cmd_in2, cmd_in1}),
    .pop    (pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // The FIFO read register doubles as the ALU issue register, so alu_* hold between issues.
  assign alu_in1          = head[0 +: WIDTH];
  assign alu_in2          = head[WIDTH +: WIDTH];
  assign alu_op           = head[2*WIDTH +: 4];
  assign issue_tag        = head[ENT_W-1 -: TAG_W];
  assign alu_invalid_data = !op_is_legal(alu_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_tag    <= '0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_out;
      rsp_zero   <= alu_zero;
      rsp_error  <= alu_error;
      rsp_tag    <= issue_tag;
    end else if (rsp_hs) begin
      rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (rsp_hs) begin
      if (stat_ops != 16'hFFFF) begin
        stat_ops <= stat_ops + 16'd1;
      end
      if (rsp_error && (stat_errs != 16'hFFFF)) begin
        stat_errs <= stat_errs + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: combinational ALU model, table-driven vectors and a response scoreboard.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_in1;
  logic [7:0]  cmd_in2;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic [7:0]  alu_in1;
  logic [7:0]  alu_in2;
  logic [3:0]  alu_op;
  logic        alu_invalid_data;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        alu_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_error;
  logic [3:0]  rsp_tag;
  logic [15:0] stat_ops;
  logic [15:0] stat_errs;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [3:0]  op;
    logic [3:0]  tag;
    logic [15:0] res;
    logic        zero;
    logic        err;
    logic        inv;
  } vec_t;

  typedef struct packed {
    logic [15:0] res;
    logic        zero;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  vec_t vecs[9];
  exp_t exp_q[$];
  int   hs_cyc[$];
  exp_t mon_e;

  alu_cmd_issuer #(.WIDTH(8), .DEPTH(4), .TAG_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_in1          (cmd_in1),
    .cmd_in2          (cmd_in2),
    .cmd_op           (cmd_op),
    .cmd_tag          (cmd_tag),
    .alu_in1          (alu_in1),
    .alu_in2          (alu_in2),
    .alu_op           (alu_op),
    .alu_invalid_data (alu_invalid_data),
    .alu_out          (alu_out),
    .alu_zero         (alu_zero),
    .alu_error        (alu_error),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_zero         (rsp_zero),
    .rsp_error        (rsp_error),
    .rsp_tag          (rsp_tag),
    .stat_ops         (stat_ops),
    .stat_errs        (stat_errs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External combinational ALU: illegal op or divide by zero gives out=1, error=1.
  always_comb begin
    alu_out   = 16'd1;
    alu_error = 1'b1;
    if (!alu_invalid_data) begin
      case (alu_op)
        4'b0000: begin alu_out = 16'(alu_in1) + 16'(alu_in2); alu_error = 1'b0; end
        4'b0001: begin alu_out = 16'(alu_in1) - 16'(alu_in2); alu_error = 1'b0; end
        4'b0010: begin alu_out = 16'(alu_in1) * 16'(alu_in2); alu_error = 1'b0; end
        4'b0100: begin
          if (alu_in2 != 8'd0) begin
            alu_out   = {8'd0, alu_in1 / alu_in2};
            alu_error = 1'b0;
          end
        end
        default: begin end
      endcase
    end
    alu_zero = (alu_out == 16'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
        chk("rsp_zero_err_tag", 32'({rsp_zero, rsp_error, rsp_tag}),
            32'({mon_e.zero, mon_e.err, mon_e.tag}));
      end
    end
  end

  // Called away from the clock edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [3:0] tag, input logic [15:0] res, input logic zero,
                      input logic err);
    int   n = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_in1   = a;
    cmd_in2   = b;
    cmd_op    = op;
    cmd_tag   = tag;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      e.res  = res;
      e.zero = zero;
      e.err  = err;
      e.tag  = tag;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd200, 8'd100, 4'b0000, 4'd3,  16'd300,   1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'd9,   8'd0,   4'b0100, 4'd4,  16'd1,     1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'd5,   8'd5,   4'b0001, 4'd5,  16'd0,     1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'd3,   8'd4,   4'b1111, 4'd6,  16'd1,     1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'd255, 8'd255, 4'b0010, 4'd7,  16'hFE01,  1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'd100, 8'd7,   4'b0100, 4'd8,  16'd14,    1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'd0,   8'd0,   4'b0000, 4'd10, 16'd0,     1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'd8,   8'd8,   4'b0011, 4'd11, 16'd1,     1'b0, 1'b1, 1'b1};
    vecs[8] = '{8'd20,  8'd30,  4'b0001, 4'd2,  16'hFFF6,  1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_in1   = '0;
    cmd_in2   = '0;
    cmd_op    = '0;
    cmd_tag   = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_stat_ops", 32'(stat_ops), 32'd0);
    chk("reset_stat_errs", 32'(stat_errs), 32'd0);
    chk("reset_alu_ops", 32'({alu_in1, alu_in2, alu_op, alu_invalid_data}), 32'd0);
    chk("reset_rsp_data", 32'({rsp_result, rsp_zero, rsp_error, rsp_tag}), 32'd0);

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Single commands from idle: latency, invalid flag and result per vector.
    foreach (vecs[i]) begin
      send(vecs[i].in1, vecs[i].in2, vecs[i].op, vecs[i].tag,
           vecs[i].res, vecs[i].zero, vecs[i].err);
      @(posedge clk); #1;
      chk("lat_e1_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("issue_invalid_data", 32'(alu_invalid_data), 32'(vecs[i].inv));
      @(posedge clk); #1;
      chk("lat_e2_rsp_valid", 32'(rsp_valid), 32'd1);
      wait_idle();
      if (i == 0) chk("stat_ops_first", 32'(stat_ops), 32'd1);
      if (i == 1) chk("stat_errs_div0", 32'(stat_errs), 32'd1);
    end
    chk("stat_ops_after_table", 32'(stat_ops), 32'd9);
    chk("stat_errs_after_table", 32'(stat_errs), 32'd3);

    // Backpressure: one in flight plus four queued fills the block.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(8'(i + 1), 8'd10, 4'b0010, 4'(i), 16'(10 * (i + 1)), 1'b0, 1'b0);
    end
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("stall_rsp_stable", 32'({rsp_valid, rsp_result, rsp_zero, rsp_error, rsp_tag}),
          32'({1'b1, 16'd10, 1'b0, 1'b0, 4'd0}));
    end
    chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    hs_cyc.delete();
    rsp_ready = 1'b1;
    wait_idle();
    chk("drain_rsp_count", 32'(hs_cyc.size()), 32'd5);
    for (int k = 1; k < hs_cyc.size(); k++) begin
      chk("rsp_spacing", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd2);
    end
    chk("stat_ops_after_burst", 32'(stat_ops), 32'd14);

    // Reset while a response is pending and two commands are queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(8'd7, 8'd2, 4'b0000, 4'(12 + i), 16'd9, 1'b0, 1'b0);
    end
    begin
      int n = 0;
      while (!rsp_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("in_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("in_reset_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_reset_stat_ops", 32'(stat_ops), 32'd0);
    chk("post_reset_stat_errs", 32'(stat_errs), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_rsp", 32'(rsp_valid), 32'd0);

    // Saturation of the op counter.
    force dut.stat_ops = 16'hFFFE;
    @(posedge clk); #1;
    release dut.stat_ops;
    send(8'd1, 8'd1, 4'b0000, 4'd1, 16'd2, 1'b0, 1'b0);
    wait_idle();
    chk("stat_ops_reach_max", 32'(stat_ops), 32'hFFFF);
    send(8'd2, 8'd3, 4'b0010, 4'd2, 16'd6, 1'b0, 1'b0);
    send(8'd9, 8'd3, 4'b0100, 4'd3, 16'd3, 1'b0, 1'b0);
    wait_idle();
    chk("stat_ops_saturated", 32'(stat_ops), 32'hFFFF);
    chk("stat_errs_no_err", 32'(stat_errs), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
